alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: the instruction datapath (port 0) and an auxiliary unit such as a debug or address-calculation engine (port 1). Uses round-robin arbitration and a valid/ready request channel. Operands are registered before they drive the ALU, and the result and flags are registered into a response held until the owner accepts it. Sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU; the result and flags are held as a response until the owner takes it.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [WIDTH-1:0]  resp_result,
    output logic [3:0]        resp_flags,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_v,
    input  logic              alu_c,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q, result_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [3:0]        flags_q;
    logic              resp0_valid_q, resp1_valid_q;
    logic              last_grant_q, owner_q;
    logic              grant_d, accept, transfer;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_d = last_grant_q;
        if (req0_valid && req1_valid) grant_d = ~last_grant_q;
        else if (req0_valid)          grant_d = 1'b0;
        else if (req1_valid)          grant_d = 1'b1;
        req0_ready = (state_q == IDLE) && req0_valid && !grant_d;
        req1_ready = (state_q == IDLE) && req1_valid && grant_d;
    end

    assign accept   = req0_ready | req1_ready;
    assign transfer = owner_q ? (resp1_valid_q & resp1_ready) : (resp0_valid_q & resp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= '0;
            result_q      <= '0;
            flags_q       <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= grant_d ? req1_a : req0_a;
                        b_q          <= grant_d ? req1_b : req0_b;
                        ctrl_q       <= grant_d ? req1_ctrl : req0_ctrl;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q      <= alu_result;
                    flags_q       <= {alu_v, alu_c, alu_n, alu_z};
                    resp0_valid_q <= ~owner_q;
                    resp1_valid_q <= owner_q;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (transfer) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = ctrl_q;
    assign resp_result = result_q;
    assign resp_flags  = flags_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU and a queue-based arbitration model.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp_result, alu_a, alu_b, alu_result;
    logic [3:0]  resp_flags;
    logic [2:0]  alu_control;
    logic        alu_v, alu_c, alu_n, alu_z, busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_last = 1'b1;
    op_t q0[$], q1[$];
    logic [35:0] res_log[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
        .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .busy(busy)
    );

    // Returns {V,C,N,Z,result}; C is the carry out of a + ~b + 1 for subtraction.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        v, cy;
        s = '0; r = '0; v = 1'b0; cy = 1'b0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = a ^ b;
            default: r = '0;
        endcase
        return {v, cy, r[31], (r == 32'd0), r};
    endfunction

    always_comb {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_ref(alu_a, alu_b, alu_control);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int p, input bit v, input op_t o);
        if (p == 0) begin
            req0_valid = v; req0_a = o.a; req0_b = o.b; req0_ctrl = o.c;
        end else begin
            req1_valid = v; req1_a = o.a; req1_b = o.b; req1_ctrl = o.c;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drains q0/q1 through the DUT; hold < 0 picks a random response back-pressure per op.
    task automatic serve(input int hold);
        int g, exp_g, n, h;
        op_t o;
        logic [35:0] exp_r;
        while (q0.size() + q1.size() > 0) begin
            if (q0.size() > 0) drive(0, 1'b1, q0[0]); else drive(0, 1'b0, '0);
            if (q1.size() > 0) drive(1, 1'b1, q1[0]); else drive(1, 1'b0, '0);
            #1;
            if (q0.size() > 0 && q1.size() > 0) exp_g = model_last ? 0 : 1;
            else exp_g = (q0.size() > 0) ? 0 : 1;
            n = 0;
            while (!req0_ready && !req1_ready && n < 10) begin
                @(negedge clk); #1; n++;
            end
            if (n >= 10) begin
                check("ready_timeout", 1, 0);
                return;
            end
            check("idle_busy", busy, 0);
            check("ready_onehot", req0_ready & req1_ready, 0);
            g = req1_ready ? 1 : 0;
            check("grant", g, exp_g);
            o = (g == 1) ? q1.pop_front() : q0.pop_front();
            model_last = g[0];
            exp_r = alu_ref(o.a, o.b, o.c);
            @(negedge clk);
            if (g == 0) begin
                if (q0.size() > 0) drive(0, 1'b1, q0[0]); else drive(0, 1'b0, '0);
            end else begin
                if (q1.size() > 0) drive(1, 1'b1, q1[0]); else drive(1, 1'b0, '0);
            end
            #1;
            check("exec_busy", busy, 1);
            check("exec_alu_a", alu_a, o.a);
            check("exec_alu_b", alu_b, o.b);
            check("exec_alu_ctrl", alu_control, o.c);
            check("exec_no_resp", {resp0_valid, resp1_valid}, 0);
            check("exec_no_ready", {req0_ready, req1_ready}, 0);
            @(negedge clk); #1;
            h = (hold < 0) ? $urandom_range(0, 2) : hold;
            for (int i = 0; i <= h; i++) begin
                check("resp_owner_valid", g ? resp1_valid : resp0_valid, 1);
                check("resp_other_valid", g ? resp0_valid : resp1_valid, 0);
                check("resp_result", resp_result, exp_r[31:0]);
                check("resp_flags", resp_flags, exp_r[35:32]);
                check("resp_busy", busy, 1);
                check("resp_no_ready", {req0_ready, req1_ready}, 0);
                if (i < h) begin
                    if (g == 0) begin resp0_ready = 1'b0; resp1_ready = 1'b1; end
                    else begin resp1_ready = 1'b0; resp0_ready = 1'b1; end
                    @(negedge clk); #1;
                end
            end
            res_log.push_back({resp_flags, resp_result});
            if (g == 0) begin resp0_ready = 1'b1; resp1_ready = 1'b0; end
            else begin resp1_ready = 1'b1; resp0_ready = 1'b0; end
            @(negedge clk);
            resp0_ready = 1'b0; resp1_ready = 1'b0;
            #1;
            check("after_xfer_valid", {resp0_valid, resp1_valid}, 0);
            check("after_xfer_busy", busy, 0);
        end
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        o.b = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
        o.c = 3'($urandom_range(0, 7));
        return o;
    endfunction

    initial begin
        op_t o;
        #1;
        check("rst_busy", busy, 0);
        check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_result", resp_result, 0);
        check("rst_flags", resp_flags, 0);
        check("rst_alu", {alu_a, alu_b, alu_control}, 0);
        do_reset();
        @(negedge clk);

        q0.push_back('{a: 32'd3, b: 32'd4, c: 3'd0});
        serve(0);
        check("add_result", res_log[0][31:0], 32'h0000_0007);
        check("add_flags", res_log[0][35:32], 4'b0000);

        q1.push_back('{a: 32'd5, b: 32'd7, c: 3'd1});
        serve(0);
        check("sub_result", res_log[1][31:0], 32'hFFFF_FFFE);
        check("sub_flags", res_log[1][35:32], 4'b0010);

        // port 1 waits valid through the 5-cycle hold of port 0's response
        q0.push_back('{a: 32'hFFFF_FFFF, b: 32'd1, c: 3'd0});
        q1.push_back('{a: 32'd123, b: 32'd456, c: 3'd6});
        serve(5);
        check("carry_result", res_log[2][31:0], 32'h0000_0000);
        check("carry_flags", res_log[2][35:32], 4'b0101);
        check("undef_result", res_log[3][31:0], 32'h0000_0000);
        check("undef_flags", res_log[3][35:32], 4'b0001);

        q0.push_back(rand_op());
        serve(-1);
        q0.push_back(rand_op());
        q1.push_back(rand_op());
        serve(-1);

        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        serve(-1);

        o = '{a: 32'd9, b: 32'd1, c: 3'd1};
        drive(0, 1'b1, o);
        #1;
        check("mid_ready", req0_ready, 1);
        @(negedge clk);
        drive(0, 1'b0, '0);
        @(negedge clk); #1;
        check("mid_resp_valid", resp0_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {resp0_valid, resp1_valid}, 0);
        check("mid_rst_busy", busy, 0);
        model_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q0.push_back('{a: 32'd10, b: 32'd20, c: 3'd0});
        serve(0);
        check("post_rst_result", res_log[res_log.size()-1][31:0], 32'd30);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) != 0) q0.push_back(rand_op());
            if ($urandom_range(0, 2) != 0) q1.push_back(rand_op());
            if ($urandom_range(0, 3) == 0) q0.push_back(rand_op());
            serve(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
